serv_ram32_resp: RTL

SERV_RAM32_RESP -- requirements
Module: serv_ram32_resp

---
 rtl/serv_ram32_resp.sv | 116 +++++++++++
 1 files changed

// File: rtl/serv_ram32_resp.sv
// rtl/serv_ram32_resp.sv - 32x32 byte-writable RAM with registered response and post-reset clear sweep
module serv_ram32_resp #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_ram_addr,
  input  logic [31:0] i_ram_din,
  input  logic [3:0]  i_ram_we,
  input  logic        i_ram_en,
  output logic [31:0] o_ram_dout,
  output logic        o_rvalid,
  output logic        o_ready,
  output logic [4:0]  o_clr_addr
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    CLEAR      = 2'd1,
    READY      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  clr_addr_q, clr_addr_d;
  logic [31:0] dout_q, dout_d;
  logic        rvalid_q, rvalid_d;

  // Storage carries no reset; the clear sweep is the only way it gets zeroed.
  logic [31:0] mem [32];

  logic        mem_wr;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] rd_word;
  logic [31:0] merged_word;

  // Old word at the request address with the enabled byte lanes replaced by new data.
  always_comb begin
    rd_word     = mem[i_ram_addr];
    merged_word = rd_word;
    for (int k = 0; k < 4; k++) begin
      if (i_ram_we[k]) begin
        merged_word[8*k +: 8] = i_ram_din[8*k +: 8];
      end
    end
  end

  // Next-state, sweep counter, response and array write-port selection.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    dout_d     = dout_q;
    rvalid_d   = 1'b0;
    mem_wr     = 1'b0;
    mem_waddr  = i_ram_addr;
    mem_wdata  = merged_word;
    case (state_q)
      RESET_HOLD: begin
        clr_addr_d = 5'd0;
        state_d    = CLEAR_ON_RESET ? CLEAR : READY;
      end
      CLEAR: begin
        // Requests are ignored here; the write port belongs to the sweep.
        mem_wr    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = 32'h0;
        if (clr_addr_q == 5'd31) begin
          clr_addr_d = 5'd0;
          state_d    = READY;
        end else begin
          clr_addr_d = clr_addr_q + 5'd1;
        end
      end
      READY: begin
        if (i_ram_en) begin
          // Write-first: a write returns the merged word on the same edge.
          rvalid_d = 1'b1;
          dout_d   = merged_word;
          mem_wr   = (i_ram_we != 4'b0000);
        end
      end
      default: begin
        state_d    = RESET_HOLD;
        clr_addr_d = 5'd0;
      end
    endcase
  end

  // Control and response registers, forced to idle values while reset is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= RESET_HOLD;
      clr_addr_q <= 5'd0;
      dout_q     <= 32'h0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      dout_q     <= dout_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Array write port; state is RESET_HOLD during reset so no write can occur.
  always_ff @(posedge i_clk) begin
    if (mem_wr) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign o_ram_dout = dout_q;
  assign o_rvalid   = rvalid_q;
  assign o_ready    = (state_q == READY);
  assign o_clr_addr = clr_addr_q;

endmodule
